// File: rtl/scan_cmd_engine.sv
// scan_cmd_engine
//   Byte-command test controller sitting between a UART rx/tx pair and the
//   pins of a scan-chain part. Commands arrive as single bytes, 16-bit counts
//   as two bytes (high first). It drives the part clock/reset/scan-enable/
//   test-mode, NCHAINS parallel scan-in lines and the primary inputs, and
//   returns scan-out bytes, primary outputs and 'k' acknowledges over tx.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   rx_data, new_rx_data  received byte and its one-cycle strobe
//   tx_data_o, tx_start_o transmit byte and one-cycle request
//   tx_ready_i            transmitter idle
//   dut_clk_o, dut_rst_o  part clock and part reset
//   dut_se_o, dut_tm_o    scan enable, test mode
//   dut_si_o, dut_so_i    scan-in / scan-out, bit k = chain k
//   pis_o, pos_i          primary inputs / outputs of the part
//   busy_o                high whenever the controller is not idle
module scan_cmd_engine #(
    parameter int NCHAINS     = 1,
    parameter int NPIS        = 14,
    parameter int NPOS        = 11,
    parameter int HALF_PERIOD = 1,
    parameter int RST_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               new_rx_data,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_ready_i,
    output logic               dut_clk_o,
    output logic               dut_rst_o,
    output logic               dut_se_o,
    output logic               dut_tm_o,
    output logic [NCHAINS-1:0] dut_si_o,
    input  logic [NCHAINS-1:0] dut_so_i,
    output logic [NPIS-1:0]    pis_o,
    input  logic [NPOS-1:0]    pos_i,
    output logic               busy_o
);
    localparam int PI_BYTES = (NPIS + 7) / 8;
    localparam int PO_BYTES = (NPOS + 7) / 8;
    localparam int PI_W     = PI_BYTES * 8;
    localparam int PO_W     = PO_BYTES * 8;
    localparam int HC_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [7:0] CMD_R = 8'h72;
    localparam logic [7:0] CMD_E = 8'h65;
    localparam logic [7:0] CMD_F = 8'h66;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_G = 8'h67;
    localparam logic [7:0] CMD_X = 8'h78;
    localparam logic [7:0] CMD_I = 8'h69;
    localparam logic [7:0] CMD_O = 8'h6F;
    localparam logic [7:0] CMD_P = 8'h70;
    localparam logic [7:0] ACK_K = 8'h6B;

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, SETUP, PULSE_HI, PULSE_LO,
        SCAN_RX, PI_RX, PO_SEND, TX_REQ, TX_WLO, TX_WHI
    } state_t;

    state_t              state, state_nxt;
    logic [HC_W-1:0]     hc;
    logic [15:0]         cnt, cnt_nxt;
    logic [7:0]          idx, idx_nxt;
    logic [7:0]          cmd, cmd_nxt;
    logic [NCHAINS-1:0]  si, si_nxt;
    logic [NPIS-1:0]     pis, pis_nxt;
    logic [PI_W-1:0]     pi_buf, pi_buf_nxt, pi_merge;
    logic [PO_W-1:0]     po_buf, po_buf_nxt;
    logic [7:0]          tx_byte, tx_byte_nxt;
    logic                last_tx, last_nxt;
    logic                stop_req, stop_nxt;
    logic [NCHAINS-1:0]  so_q;
    logic [NPOS-1:0]     pos_q;
    logic [7:0]          so_byte, po_byte;
    logic                phase_end, p_seen, running;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        cmd_nxt     = cmd;
        si_nxt      = si;
        pis_nxt     = pis;
        pi_buf_nxt  = pi_buf;
        po_buf_nxt  = po_buf;
        tx_byte_nxt = tx_byte;
        last_nxt    = last_tx;
        stop_nxt    = stop_req;
        so_byte     = 8'(so_q);
        po_byte     = 8'(po_buf >> {idx, 3'b000});
        pi_merge    = (pi_buf & ~(PI_W'(8'hFF) << {idx, 3'b000}))
                    | (PI_W'(rx_data) << {idx, 3'b000});
        phase_end   = (hc == HC_W'(HALF_PERIOD - 1));
        p_seen      = new_rx_data && (rx_data == CMD_P);

        case (state)
            IDLE: if (new_rx_data) begin
                case (rx_data)
                    CMD_R: begin
                        cmd_nxt = rx_data; cnt_nxt = 16'(RST_CYCLES); state_nxt = PULSE_HI;
                    end
                    CMD_E, CMD_S, CMD_G, CMD_X: begin
                        cmd_nxt = rx_data; state_nxt = CNT_HI;
                    end
                    CMD_F: begin
                        cmd_nxt = rx_data; stop_nxt = 1'b0; state_nxt = PULSE_HI;
                    end
                    CMD_I: begin
                        cmd_nxt = rx_data; idx_nxt = '0; state_nxt = PI_RX;
                    end
                    CMD_O: begin
                        // Snapshot so all returned bytes describe the same instant.
                        cmd_nxt = rx_data; idx_nxt = '0; po_buf_nxt = PO_W'(pos_q);
                        state_nxt = PO_SEND;
                    end
                    default: ;
                endcase
            end
            CNT_HI: if (new_rx_data) begin
                cnt_nxt = {rx_data, cnt[7:0]}; state_nxt = CNT_LO;
            end
            CNT_LO: if (new_rx_data) begin
                cnt_nxt = {cnt[15:8], rx_data};
                if ({cnt[15:8], rx_data} == 16'd0) begin
                    tx_byte_nxt = ACK_K; last_nxt = 1'b1; state_nxt = TX_REQ;
                end else if (cmd == CMD_E) begin
                    state_nxt = PULSE_HI;
                end else if (cmd == CMD_G) begin
                    tx_byte_nxt = so_byte; last_nxt = 1'b0; state_nxt = TX_REQ;
                end else begin
                    state_nxt = SCAN_RX;
                end
            end
            SCAN_RX: if (new_rx_data) begin
                si_nxt = rx_data[NCHAINS-1:0];
                if (cmd == CMD_X) begin
                    tx_byte_nxt = so_byte; last_nxt = 1'b0; state_nxt = TX_REQ;
                end else begin
                    state_nxt = SETUP;
                end
            end
            // Holds scan-in steady for a full half period before the rising edge.
            SETUP: if (phase_end) state_nxt = PULSE_HI;
            PULSE_HI: begin
                if (cmd == CMD_F && p_seen) stop_nxt = 1'b1;
                if (phase_end) state_nxt = PULSE_LO;
            end
            PULSE_LO: begin
                if (cmd == CMD_F && p_seen) stop_nxt = 1'b1;
                if (phase_end) begin
                    if (cmd == CMD_F) begin
                        if (stop_req || p_seen) begin
                            tx_byte_nxt = ACK_K; last_nxt = 1'b1; state_nxt = TX_REQ;
                        end else begin
                            state_nxt = PULSE_HI;
                        end
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            // Data-returning scans end silently; the rest acknowledge.
                            if (cmd == CMD_G || cmd == CMD_X) begin
                                state_nxt = IDLE;
                            end else begin
                                tx_byte_nxt = ACK_K; last_nxt = 1'b1; state_nxt = TX_REQ;
                            end
                        end else if (cmd == CMD_G) begin
                            tx_byte_nxt = so_byte; last_nxt = 1'b0; state_nxt = TX_REQ;
                        end else if (cmd == CMD_S || cmd == CMD_X) begin
                            state_nxt = SCAN_RX;
                        end else begin
                            state_nxt = PULSE_HI;
                        end
                    end
                end
            end
            PI_RX: if (new_rx_data) begin
                pi_buf_nxt = pi_merge;
                if (idx == 8'(PI_BYTES - 1)) begin
                    pis_nxt = pi_merge[NPIS-1:0];
                    tx_byte_nxt = ACK_K; last_nxt = 1'b1; state_nxt = TX_REQ;
                end else begin
                    idx_nxt = idx + 8'd1;
                end
            end
            PO_SEND: begin
                tx_byte_nxt = po_byte;
                last_nxt    = (idx == 8'(PO_BYTES - 1));
                idx_nxt     = idx + 8'd1;
                state_nxt   = TX_REQ;
            end
            TX_REQ: if (tx_ready_i) state_nxt = TX_WLO;
            TX_WLO: if (!tx_ready_i) state_nxt = TX_WHI;
            TX_WHI: if (tx_ready_i) begin
                if (last_tx)            state_nxt = IDLE;
                else if (cmd == CMD_G)  state_nxt = PULSE_HI;
                else if (cmd == CMD_X)  state_nxt = SETUP;
                else if (cmd == CMD_O)  state_nxt = PO_SEND;
                else                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        so_q   <= dut_so_i;
        pos_q  <= pos_i;
        pi_buf <= pi_buf_nxt;
        po_buf <= po_buf_nxt;
        if (rst) begin
            state    <= IDLE;
            hc       <= '0;
            cnt      <= '0;
            idx      <= '0;
            cmd      <= '0;
            si       <= '0;
            pis      <= '0;
            tx_byte  <= '0;
            last_tx  <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            hc       <= (state_nxt != state) ? '0 : hc + 1'b1;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            cmd      <= cmd_nxt;
            si       <= si_nxt;
            pis      <= pis_nxt;
            tx_byte  <= tx_byte_nxt;
            last_tx  <= last_nxt;
            stop_req <= stop_nxt;
        end
    end

    assign running    = (state == PULSE_HI) || (state == PULSE_LO);
    assign dut_clk_o  = (state == PULSE_HI);
    assign dut_rst_o  = running && (cmd == CMD_R);
    assign dut_se_o   = !(running && (cmd == CMD_E || cmd == CMD_F));
    assign dut_tm_o   = dut_se_o;
    assign dut_si_o   = si;
    assign pis_o      = pis;
    assign tx_data_o  = tx_byte;
    assign tx_start_o = (state == TX_REQ) && tx_ready_i;
    assign busy_o     = (state != IDLE);
endmodule

// File: tb/tb_scan_cmd_engine.sv
module tb_scan_cmd_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        new_rx_data = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_ready = 1'b1;
    logic        dut_clk_o, dut_rst_o, dut_se_o, dut_tm_o;
    logic [3:0]  dut_si_o;
    logic [3:0]  dut_so_i;
    logic [13:0] pis_o;
    logic [10:0] pos_i = 11'h000;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    scan_cmd_engine #(
        .NCHAINS(4), .NPIS(14), .NPOS(11), .HALF_PERIOD(2), .RST_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_ready_i(tx_ready),
        .dut_clk_o(dut_clk_o), .dut_rst_o(dut_rst_o), .dut_se_o(dut_se_o),
        .dut_tm_o(dut_tm_o), .dut_si_o(dut_si_o), .dut_so_i(dut_so_i),
        .pis_o(pis_o), .pos_i(pos_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts a request, stays busy for three cycles.
    logic [7:0] tx_log [64];
    int         tx_n = 0;
    int         txb  = 0;
    always @(posedge clk) begin
        if (tx_start_o) begin
            tx_log[tx_n[5:0]] <= tx_data_o;
            tx_n     <= tx_n + 1;
            tx_ready <= 1'b0;
            txb      <= 3;
        end else if (txb != 0) begin
            txb <= txb - 1;
            if (txb == 1) tx_ready <= 1'b1;
        end
    end

    // Scan chains: 4-bit shift registers clocked on part-clock rising edges.
    logic [3:0] ch [4];
    logic [3:0] pre_v [4];
    logic       preload = 1'b0;
    logic       dclk_q = 1'b0;
    int         rise_n = 0;
    int         fall_n = 0;
    int         hi_len = 0;
    int         bad_hi = 0;
    logic [3:0] rise_si [64];
    always @(posedge clk) begin
        dclk_q <= dut_clk_o;
        if (dut_clk_o === 1'b1 && dclk_q == 1'b0) begin
            rise_n <= rise_n + 1;
            rise_si[rise_n[5:0]] <= dut_si_o;
        end
        if (dut_clk_o === 1'b1) begin
            hi_len <= hi_len + 1;
        end else begin
            if (dclk_q) begin
                fall_n <= fall_n + 1;
                if (hi_len != 2) bad_hi <= bad_hi + 1;
            end
            hi_len <= 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (preload) ch[k] <= pre_v[k];
            else if (dut_clk_o === 1'b1 && dclk_q == 1'b0) ch[k] <= {ch[k][2:0], dut_si_o[k]};
        end
    end
    always_comb begin
        for (int k = 0; k < 4; k++) dut_so_i[k] = ch[k][3];
    end

    int rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_n <= rd && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_n > rd) begin
            chk(tag, 32'(tx_log[rd[5:0]]), 32'(exp));
            rd++;
        end else begin
            chk({tag, "_timeout"}, 32'hDEAD, 32'(exp));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic load_chains(input logic [3:0] c0, input logic [3:0] c1,
                               input logic [3:0] c2, input logic [3:0] c3);
        pre_v[0] = c0; pre_v[1] = c1; pre_v[2] = c2; pre_v[3] = c3;
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        tick(2);
    endtask

    initial begin
        int r0, f0;
        logic [15:0] pat;
        logic se_run, tm_run;

        load_chains(4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        tick(2);
        chk("rst_clk", 32'(dut_clk_o), 32'd0);
        chk("rst_dutrst", 32'(dut_rst_o), 32'd0);
        chk("rst_se", 32'(dut_se_o), 32'd1);
        chk("rst_tm", 32'(dut_tm_o), 32'd1);
        chk("rst_si", 32'(dut_si_o), 32'd0);
        chk("rst_pis", 32'(pis_o), 32'd0);
        chk("rst_txstart", 32'(tx_start_o), 32'd0);
        chk("rst_txdata", 32'(tx_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        tick(1);

        // Unknown byte and stray 'p' in idle are ignored.
        send(8'h7A);
        tick(1);
        chk("ignore_z_busy", 32'(busy_o), 32'd0);
        send(8'h70);
        tick(3);
        chk("ignore_p_busy", 32'(busy_o), 32'd0);
        chk("ignore_p_tx", 32'(tx_n), 32'd0);

        // 'e' 3 pulses: 2 high / 2 low each, functional mode during the run.
        r0 = rise_n;
        send(8'h65); send(8'h00); send(8'h03);
        se_run = dut_se_o;
        tm_run = dut_tm_o;
        for (int i = 0; i < 16; i++) begin
            pat[15-i] = dut_clk_o;
            @(negedge clk);
        end
        chk("e3_pattern", 32'(pat), 32'h0000CCC0);
        chk("e3_se_run", 32'(se_run), 32'd0);
        chk("e3_tm_run", 32'(tm_run), 32'd0);
        wait_tx("e3_ack", 8'h6B);
        wait_idle("e3_idle");
        chk("e3_pulses", 32'(rise_n - r0), 32'd3);
        chk("e3_se_after", 32'(dut_se_o), 32'd1);

        // Zero count: immediate acknowledge, no pulses.
        r0 = rise_n;
        send(8'h65); send(8'h00); send(8'h00);
        wait_tx("e0_ack", 8'h6B);
        wait_idle("e0_idle");
        chk("e0_pulses", 32'(rise_n - r0), 32'd0);

        // Count using both bytes.
        r0 = rise_n;
        send(8'h65); send(8'h01); send(8'h01);
        wait_tx("e257_ack", 8'h6B);
        wait_idle("e257_idle");
        chk("e257_pulses", 32'(rise_n - r0), 32'd257);

        // Part reset: held for RST_CYCLES pulses.
        r0 = rise_n;
        send(8'h72);
        tick(1);
        chk("r_rst_high", 32'(dut_rst_o), 32'd1);
        wait_tx("r_ack", 8'h6B);
        wait_idle("r_idle");
        chk("r_pulses", 32'(rise_n - r0), 32'd4);
        chk("r_rst_low", 32'(dut_rst_o), 32'd0);

        // Scan load of two vectors.
        r0 = rise_n;
        send(8'h73); send(8'h00); send(8'h02); send(8'h05);
        tick(10);
        send(8'h0A);
        wait_tx("s_ack", 8'h6B);
        wait_idle("s_idle");
        chk("s_pulses", 32'(rise_n - r0), 32'd2);
        chk("s_si_first", 32'(rise_si[r0[5:0]]), 32'h5);
        chk("s_si_second", 32'(rise_si[6'(r0 + 1)]), 32'hA);

        // Scan unload of chains preloaded with ones: four 0x0F bytes, no ack.
        load_chains(4'hF, 4'hF, 4'hF, 4'hF);
        r0 = rise_n;
        send(8'h67); send(8'h00); send(8'h04);
        for (int j = 0; j < 4; j++) wait_tx("g4_byte", 8'h0F);
        wait_idle("g4_idle");
        tick(10);
        chk("g4_pulses", 32'(rise_n - r0), 32'd4);
        chk("g4_no_ack", 32'(tx_n), 32'(rd));

        // Exchange: so=0x2 returned, si=0x3 at the rising edge.
        load_chains(4'h0, 4'hF, 4'h0, 4'h0);
        r0 = rise_n;
        send(8'h78); send(8'h00); send(8'h01); send(8'h03);
        wait_tx("x_so", 8'h02);
        wait_idle("x_idle");
        tick(5);
        chk("x_pulses", 32'(rise_n - r0), 32'd1);
        chk("x_si", 32'(rise_si[r0[5:0]]), 32'h3);
        chk("x_no_ack", 32'(tx_n), 32'(rd));

        // Unload where the chain contents change with each shift (si=0x3 shifts in).
        load_chains(4'h8, 4'h7, 4'h0, 4'h0);
        send(8'h67); send(8'h00); send(8'h02);
        wait_tx("g2_first", 8'h01);
        wait_tx("g2_second", 8'h02);
        wait_idle("g2_idle");

        // Primary inputs.
        send(8'h69); send(8'hFF);
        tick(3);
        chk("i_hold", 32'(pis_o), 32'h0);
        send(8'hFF);
        wait_tx("i_ack", 8'h6B);
        chk("i_pis_ff", 32'(pis_o), 32'h3FFF);
        wait_idle("i_idle");
        send(8'h69); send(8'h34);
        tick(3);
        chk("i_hold2", 32'(pis_o), 32'h3FFF);
        send(8'h92);
        wait_tx("i_ack2", 8'h6B);
        chk("i_pis_1234", 32'(pis_o), 32'h1234);
        wait_idle("i_idle2");

        // Primary outputs.
        pos_i = 11'h5A5;
        tick(2);
        send(8'h6F);
        wait_tx("o_lo", 8'hA5);
        wait_tx("o_hi", 8'h05);
        wait_idle("o_idle");
        pos_i = 11'h7FF;
        tick(2);
        send(8'h6F);
        wait_tx("o_lo2", 8'hFF);
        wait_tx("o_hi2", 8'h07);
        wait_idle("o_idle2");
        tick(5);
        chk("o_no_ack", 32'(tx_n), 32'(rd));

        // Free-run stopped by 'p' during a high phase.
        r0 = rise_n;
        f0 = fall_n;
        send(8'h66);
        tick(9);
        for (int n = 0; n < 20 && dut_clk_o !== 1'b1; n++) @(negedge clk);
        chk("f_high_before_p", 32'(dut_clk_o), 32'd1);
        send(8'h70);
        chk("f_busy_after_p", 32'(busy_o), 32'd1);
        wait_tx("f_ack", 8'h6B);
        wait_idle("f_idle");
        chk("f_clk_low", 32'(dut_clk_o), 32'd0);
        chk("f_ran", 32'(rise_n - r0 > 2), 32'd1);
        chk("f_complete", 32'(rise_n - r0), 32'(fall_n - f0));
        chk("hi_widths", 32'(bad_hi), 32'd0);

        // Reset in the middle of a run.
        send(8'h65); send(8'h00); send(8'h64);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_clk", 32'(dut_clk_o), 32'd0);
        chk("mrst_se", 32'(dut_se_o), 32'd1);
        chk("mrst_txdata", 32'(tx_data_o), 32'd0);
        chk("mrst_si", 32'(dut_si_o), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
